// File: rtl/matrix_host_ctrl_if.sv
// Host-side bundle for matrix_host_ctrl: load stream, memory host ports,
// core run control and result stream.
`default_nettype none

interface matrix_host_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              start;
   logic [2:0]        core_count;
   logic              in_valid;
   logic              in_ready;
   logic              in_is_instr;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              data_wr_en_file;
   logic [ADDR_W-1:0] data_addr_file;
   logic [DATA_W-1:0] data_file;
   logic              instr_wr_en_file;
   logic [ADDR_W-1:0] instr_addr_file;
   logic [7:0]        instr_file;
   logic [DATA_W-1:0] dataout_file;
   logic [1:0]        status0;
   logic [1:0]        status1;
   logic [1:0]        status2;
   logic [1:0]        status3;
   logic [3:0]        end_process;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              load_err;
   logic [31:0]       clock_count;

   modport slave (
      input  start, core_count, in_valid, in_is_instr, in_data, in_last,
             dataout_file, end_process, out_ready,
      output in_ready, data_wr_en_file, data_addr_file, data_file,
             instr_wr_en_file, instr_addr_file, instr_file,
             status0, status1, status2, status3,
             out_valid, out_data, out_last, busy, done, load_err, clock_count
   );

   modport master (
      output start, core_count, in_valid, in_is_instr, in_data, in_last,
             dataout_file, end_process, out_ready,
      input  in_ready, data_wr_en_file, data_addr_file, data_file,
             instr_wr_en_file, instr_addr_file, instr_file,
             status0, status1, status2, status3,
             out_valid, out_data, out_last, busy, done, load_err, clock_count
   );
endinterface

`default_nettype wire

// File: rtl/matrix_host_ctrl.sv
// Host controller: loads data/instruction memories, runs up to four cores,
// then streams the I*K result block back out of data memory.
`default_nettype none

module matrix_host_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  wire logic          clk,
   input  wire logic          reset_n,
   matrix_host_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
   } state_t;

   localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

   state_t            r_state, w_next;
   logic [2:0]        r_n;
   logic [ADDR_W:0]   r_daddr, r_iaddr;
   logic              r_dlast, r_ilast, r_load_err;
   logic [7:0]        r_i, r_j, r_k;
   logic [31:0]       r_clock_count;
   logic [ADDR_W-1:0] r_ptr;
   logic [15:0]       r_cnt;
   logic [DATA_W-1:0] r_out;

   logic        w_acc, w_d_acc, w_i_acc, w_d_wr, w_i_wr, w_d_err, w_i_err;
   logic [3:0]  w_mask;
   logic        w_run_exit, w_elem_last;
   logic [15:0] w_ik, w_base;

   assign w_acc   = (r_state == S_LOAD) && bus.in_valid;
   assign w_d_acc = w_acc && !bus.in_is_instr;
   assign w_i_acc = w_acc && bus.in_is_instr;
   // Words after the stream's last flag are swallowed silently; only overflow is an error
   assign w_d_wr  = w_d_acc && !r_dlast && (r_daddr != c_depth);
   assign w_i_wr  = w_i_acc && !r_ilast && (r_iaddr != c_depth);
   assign w_d_err = w_d_acc && !r_dlast && (r_daddr == c_depth);
   assign w_i_err = w_i_acc && !r_ilast && (r_iaddr == c_depth);

   // Core i owns end_process bit 3-i; enabled cores fill the mask from the top
   assign w_mask      = ~(4'b1111 >> r_n);
   assign w_run_exit  = (bus.end_process & w_mask) == w_mask;
   assign w_ik        = {8'b0, r_i} * {8'b0, r_k};
   assign w_base      = 16'd3 + {8'b0, r_i} * {8'b0, r_j} + {8'b0, r_j} * {8'b0, r_k};
   assign w_elem_last = (r_cnt == w_ik - 16'd1);

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (bus.start) w_next = S_LOAD;
         S_LOAD:    if (r_dlast && r_ilast) w_next = S_RUN;
         S_RUN:     if (w_run_exit) w_next = (w_ik == 16'd0) ? S_DONE : S_RD_ADDR;
         S_RD_ADDR: w_next = S_RD_WAIT;
         S_RD_WAIT: w_next = S_RD_OUT;
         S_RD_OUT:  if (bus.out_ready) w_next = w_elem_last ? S_DONE : S_RD_ADDR;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready         = (r_state == S_LOAD);
      bus.data_wr_en_file  = w_d_wr;
      bus.data_addr_file   = '0;
      bus.data_file        = w_d_wr ? bus.in_data : '0;
      bus.instr_wr_en_file = w_i_wr;
      bus.instr_addr_file  = (r_state == S_LOAD) ? r_iaddr[ADDR_W-1:0] : '0;
      bus.instr_file       = w_i_wr ? bus.in_data[7:0] : 8'd0;
      bus.status0          = {1'b0, (r_state == S_RUN) && w_mask[3]};
      bus.status1          = {1'b0, (r_state == S_RUN) && w_mask[2]};
      bus.status2          = {1'b0, (r_state == S_RUN) && w_mask[1]};
      bus.status3          = {1'b0, (r_state == S_RUN) && w_mask[0]};
      bus.out_valid        = (r_state == S_RD_OUT);
      bus.out_data         = (r_state == S_RD_OUT) ? r_out : '0;
      bus.out_last         = (r_state == S_RD_OUT) && w_elem_last;
      bus.busy             = (r_state != S_IDLE);
      bus.done             = (r_state == S_DONE);
      bus.load_err         = r_load_err;
      bus.clock_count      = r_clock_count;
      if (r_state == S_LOAD)         bus.data_addr_file = r_daddr[ADDR_W-1:0];
      else if (r_state == S_RD_ADDR) bus.data_addr_file = r_ptr;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_n           <= 3'd0;
         r_daddr       <= '0;
         r_iaddr       <= '0;
         r_dlast       <= 1'b0;
         r_ilast       <= 1'b0;
         r_load_err    <= 1'b0;
         r_i           <= 8'd0;
         r_j           <= 8'd0;
         r_k           <= 8'd0;
         r_clock_count <= 32'd0;
         r_ptr         <= '0;
         r_cnt         <= 16'd0;
         r_out         <= '0;
      end else begin
         if (r_state == S_IDLE && bus.start) begin
            r_n           <= (bus.core_count == 3'd0 || bus.core_count > 3'd4) ? 3'd4 : bus.core_count;
            r_daddr       <= '0;
            r_iaddr       <= '0;
            r_dlast       <= 1'b0;
            r_ilast       <= 1'b0;
            r_load_err    <= 1'b0;
            r_clock_count <= 32'd0;
            r_i           <= 8'd0;
            r_j           <= 8'd0;
            r_k           <= 8'd0;
         end
         if (w_d_wr) begin
            r_daddr <= r_daddr + 1'b1;
            if (r_daddr == '0)                 r_i <= bus.in_data[7:0];
            if (r_daddr == (ADDR_W+1)'(1))     r_j <= bus.in_data[7:0];
            if (r_daddr == (ADDR_W+1)'(2))     r_k <= bus.in_data[7:0];
         end
         if (w_i_wr) r_iaddr <= r_iaddr + 1'b1;
         if (w_d_acc && bus.in_last) r_dlast <= 1'b1;
         if (w_i_acc && bus.in_last) r_ilast <= 1'b1;
         if (w_d_err || w_i_err) r_load_err <= 1'b1;
         if (r_state == S_RUN) begin
            if (r_clock_count != 32'hFFFF_FFFF) r_clock_count <= r_clock_count + 32'd1;
            if (w_run_exit) begin
               r_ptr <= w_base[ADDR_W-1:0];
               r_cnt <= 16'd0;
            end
         end
         if (r_state == S_RD_WAIT) r_out <= bus.dataout_file;
         if (r_state == S_RD_OUT && bus.out_ready) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_matrix_host_ctrl.sv
// Directed bench for matrix_host_ctrl with behavioural data/instruction memories.
`default_nettype none

module tb_matrix_host_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   matrix_host_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus();
   matrix_host_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   logic [15:0] dmem [256];
   logic [7:0]  imem [256];
   int dwr_cnt, iwr_cnt, ov_cnt;
   int n_checks = 0;
   int n_pass = 0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 16'd0;
         dwr_cnt <= 0;
         iwr_cnt <= 0;
         ov_cnt  <= 0;
      end else begin
         if (bus.data_wr_en_file) begin
            dmem[bus.data_addr_file] <= bus.data_file;
            dwr_cnt <= dwr_cnt + 1;
         end
         if (bus.instr_wr_en_file) begin
            imem[bus.instr_addr_file] <= bus.instr_file;
            iwr_cnt <= iwr_cnt + 1;
         end
         if (bus.out_valid) ov_cnt <= ov_cnt + 1;
      end
      bus.dataout_file <= dmem[bus.data_addr_file];
   end

   typedef struct {
      logic [2:0] cc;
      logic [7:0] st;
      logic [3:0] noexit;
      logic [3:0] ex;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [7:0] st();
      return {bus.status0, bus.status1, bus.status2, bus.status3};
   endfunction

   task automatic do_start(input logic [2:0] cc);
      bus.start = 1'b1;
      bus.core_count = cc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send(input logic ii, input logic [15:0] d, input logic l);
      bus.in_valid = 1'b1;
      bus.in_is_instr = ii;
      bus.in_data = d;
      bus.in_last = l;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic wait_run();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.status0 == 2'b01) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("run_entry", 32'(ok), 32'd1);
   endtask

   task automatic wait_ov();
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("out_valid_seen", 32'(ok), 32'd1);
   endtask

   // I=J=K=2 in data[0..2], result operands in data[3..14], one dropped word, 5 instructions
   task automatic load_a(input logic [2:0] cc);
      int d0, i0;
      d0 = dwr_cnt;
      i0 = iwr_cnt;
      do_start(cc);
      chk("in_ready_load", 32'(bus.in_ready), 32'd1);
      chk("load_err_cleared", 32'(bus.load_err), 32'd0);
      for (int i = 0; i < 15; i++) send(1'b0, (i < 3) ? 16'd2 : 16'hA000 + 16'(i), i == 14);
      send(1'b0, 16'h5555, 1'b0);
      for (int i = 0; i < 5; i++) send(1'b1, 16'h0030 + 16'(i), i == 4);
      chk("data_writes", 32'(dwr_cnt - d0), 32'd15);
      chk("instr_writes", 32'(iwr_cnt - i0), 32'd5);
      chk("imem0", 32'(imem[0]), 32'h30);
      chk("imem4", 32'(imem[4]), 32'h34);
   endtask

   task automatic run_read_a(input int stall_elem);
      logic [15:0] exp;
      wait_run();
      repeat (19) @(negedge clk);
      bus.end_process = 4'hF;
      @(negedge clk);
      bus.end_process = 4'h0;
      chk("clock_count_20", bus.clock_count, 32'd20);
      chk("status_off_after_run", 32'(st()), 32'd0);
      for (int e = 0; e < 4; e++) begin
         exp = 16'hA000 + 16'd11 + 16'(e);
         wait_ov();
         chk("out_data", 32'(bus.out_data), 32'(exp));
         chk("out_last", 32'(bus.out_last), 32'(e == 3));
         if (e == stall_elem) begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk("stall_valid", 32'(bus.out_valid), 32'd1);
               chk("stall_data", 32'(bus.out_data), 32'(exp));
            end
         end
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
      chk("done_pulse", 32'(bus.done), 32'd1);
      @(negedge clk);
      chk("done_single", 32'(bus.done), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int d0, o0;
      vecs[0] = '{3'd1, 8'b01_00_00_00, 4'b0111, 4'b1000};
      vecs[1] = '{3'd2, 8'b01_01_00_00, 4'b1011, 4'b1100};
      vecs[2] = '{3'd3, 8'b01_01_01_00, 4'b1101, 4'b1110};
      vecs[3] = '{3'd4, 8'b01_01_01_01, 4'b1110, 4'b1111};
      vecs[4] = '{3'd0, 8'b01_01_01_01, 4'b0111, 4'b1111};
      vecs[5] = '{3'd7, 8'b01_01_01_01, 4'b1011, 4'b1111};

      bus.start = 1'b0; bus.core_count = 3'd0; bus.in_valid = 1'b0; bus.in_is_instr = 1'b0;
      bus.in_data = 16'd0; bus.in_last = 1'b0; bus.end_process = 4'd0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_status", 32'(st()), 32'd0);
      chk("rst_clock_count", bus.clock_count, 32'd0);
      reset_n = 1'b1;
      mem_clr = 1'b0;
      @(negedge clk);

      // Core-enable table: zero-size result so RUN goes straight to DONE
      for (int v = 0; v < 6; v++) begin
         do_start(vecs[v].cc);
         send(1'b0, 16'd0, 1'b0);
         send(1'b0, 16'd0, 1'b0);
         send(1'b0, 16'd0, 1'b1);
         send(1'b1, 16'h0042, 1'b1);
         wait_run();
         chk("status_run", 32'(st()), 32'(vecs[v].st));
         bus.end_process = vecs[v].noexit;
         repeat (3) @(negedge clk);
         chk("status_hold", 32'(st()), 32'(vecs[v].st));
         bus.end_process = vecs[v].ex;
         @(negedge clk);
         bus.end_process = 4'd0;
         chk("tbl_done", 32'(bus.done), 32'd1);
         chk("tbl_status_off", 32'(st()), 32'd0);
         chk("tbl_clock_count", bus.clock_count, 32'd4);
         @(negedge clk);
         chk("tbl_idle", 32'(bus.busy), 32'd0);
      end

      // Full job with a 10-cycle stall on the second element
      load_a(3'd4);
      run_read_a(1);

      // Overflow: 257 data words, the last one must not land anywhere
      d0 = dwr_cnt;
      o0 = ov_cnt;
      do_start(3'd1);
      for (int i = 0; i < 257; i++) send(1'b0, (i == 256) ? 16'hBEEF : 16'(i), i == 256);
      chk("load_err_set", 32'(bus.load_err), 32'd1);
      chk("overflow_writes", 32'(dwr_cnt - d0), 32'd256);
      chk("overflow_no_wrap", 32'(dmem[0]), 32'd0);
      chk("overflow_top", 32'(dmem[255]), 32'd255);
      send(1'b1, 16'd0, 1'b1);
      wait_run();
      bus.end_process = 4'b1000;
      @(negedge clk);
      bus.end_process = 4'd0;
      chk("ik0_done", 32'(bus.done), 32'd1);
      chk("ik0_clock_count", bus.clock_count, 32'd1);
      chk("ik0_no_output", 32'(ov_cnt - o0), 32'd0);
      @(negedge clk);
      chk("ik0_idle", 32'(bus.busy), 32'd0);
      chk("load_err_sticky", 32'(bus.load_err), 32'd1);

      // Reset while presenting a result element, then a clean job
      load_a(3'd2);
      wait_run();
      bus.end_process = 4'b1100;
      @(negedge clk);
      bus.end_process = 4'd0;
      wait_ov();
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_clock_count", bus.clock_count, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      load_a(3'd4);
      run_read_a(-1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/matrix_host_ctrl.md
MATRIX_HOST_CTRL -- requirements
Module: matrix_host_ctrl

Interface
REQ-001 The block SHALL have parameters: DATA_W, 16, data word width; ADDR_W, 8, memory address width (256 words per memory).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job from IDLE
- core_count  in  3  number of cores to enable; sampled on start
- in_valid / in_ready  in / out  1 / 1  load-stream handshake
- in_is_instr  in  1  1 = instruction word (low 8 bits used), 0 = data word
- in_data  in  16  load word
- in_last  in  1  marks the final word of its stream (data or instruction)
- data_wr_en_file, data_addr_file, data_file  out  1, 8, 16  data-memory host write/read port
- instr_wr_en_file, instr_addr_file, instr_file  out  1, 8, 8  instruction-memory host write port
- dataout_file  in  16  data-memory host read data, valid 1 cycle after the address
- status0..status3  out  2 each  core run control (2'b01 run, 2'b00 off)
- end_process  in  4  core finished flags; bit 3-i belongs to core i
- out_valid / out_ready  out / in  1 / 1  result-stream handshake
- out_data  out  16  result element; out_last  out  1  final element
- busy, done, load_err  out  1 each  status; clock_count  out  32  run-phase cycles

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN, RD_ADDR, RD_WAIT, RD_OUT, DONE.
REQ-004 In IDLE, start=1 SHALL latch n = core_count (0 or >4 treated as 4), clear the address counters, clock_count, load_err and the dims, and enter LOAD.
REQ-005 In LOAD, in_ready SHALL be 1; each in_valid&in_ready word SHALL be written in the same cycle to its memory at that stream's counter, which then increments.
REQ-006 Data words 0, 1, 2 SHALL additionally be captured as I, J, K (low 8 bits).
REQ-007 Each stream SHALL set a sticky last flag on in_last; words arriving for a stream whose flag is set SHALL be accepted and dropped.
REQ-008 A word arriving when its counter already equals 256 SHALL be dropped, not written, and SHALL set load_err (sticky until the next start).
REQ-009 LOAD SHALL exit to RUN in the cycle after both last flags are set.
REQ-010 In RUN, status of cores 0..n-1 SHALL be 2'b01, all others 2'b00; clock_count SHALL increment every RUN cycle and saturate at 2^32-1.
REQ-011 RUN SHALL exit when (end_process & mask) == mask, mask bit 3-i = 1 for i < n. On exit all status outputs SHALL return to 2'b00 and the FSM SHALL enter RD_ADDR with the read pointer at base = 3 + I*J + J*K, computed 16-bit and truncated to 8.
REQ-012 Readout SHALL stream I*K elements:
- RD_ADDR drives data_addr_file = pointer with data_wr_en_file = 0.
- RD_WAIT captures dataout_file.
- RD_OUT holds out_valid = 1 with stable out_data until out_ready, then increments the pointer and returns to RD_ADDR.
- out_last SHALL be 1 on element I*K-1.
REQ-013 If I*K = 0, the block SHALL go directly from RUN to DONE with no out_valid.
REQ-014 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.

Reset
REQ-016 When reset_n = 0 at a clock edge, the block SHALL, in any state including mid-load, mid-run or mid-readout:
- enter IDLE;
- drive all outputs to 0 (status 2'b00, in_ready 0, out_valid 0, clock_count 0);
- clear all counters and flags.

Verification
REQ-017 Load I=2, J=2, K=2 (data[3..14]) with 5 instruction words, n=4; end_process=4'b1111 after 20 RUN cycles -> clock_count=20, readout of addresses 11..14 in order, out_last on the 4th element, done pulse.
REQ-018 n=1 with end_process toggling 4'b0111 then 4'b1000 -> RUN exits only on bit 3; status0=01, status1..3=00 throughout.
REQ-019 out_ready held low 10 cycles during the 2nd element -> out_valid and out_data stable, no element lost or duplicated.
REQ-020 257 data words -> the 257th is not written and load_err=1; a word after in_last is dropped.
REQ-021 reset_n=0 during RD_OUT -> next cycle IDLE, out_valid=0, busy=0; a subsequent start runs a full job correctly.
